// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle control FSM for a small RV32 subset core
//               (lw, sw, lui, add/sub/and/or/sll/srl/sra). Sequences
//               IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> IDLE and
//               drives Moore-style datapath enables from state and ir.
//               Undecodable instructions and pc >= pc_limit park the FSM
//               in HALT until rst.
// Ports       : clk, rst (sync, active-high)
//               run, step, step_mode     issue control
//               ins, pc, pc_limit        instruction word / PC / PC bound
//               ir                       latched instruction register
//               pc_we, rf_we, mem_we     datapath write enables
//               wd_sel, b_sel, imm_s     datapath muxing
//               alu_op                   ALU opcode
//               state, halted, illegal   status
//               retired                  completed-instruction counter
// Config      : define MC_CTRL_STEP_EN to enable single-step issue via
//               step/step_mode; otherwise both inputs are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        step_mode,
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    input  logic [31:0] pc_limit,
    output logic [31:0] ir,
    output logic        pc_we,
    output logic        rf_we,
    output logic        mem_we,
    output logic        wd_sel,
    output logic        b_sel,
    output logic        imm_s,
    output logic [4:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_HALT   = 3'd6;

    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;
    localparam logic [6:0] c_OP_R   = 7'b0110011;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_ir;
    logic [31:0] r_retired;
    logic        r_illegal;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic       w_is_lw, w_is_sw, w_is_lui, w_is_r;
    logic       w_r_ok;
    logic [4:0] w_r_alu;
    logic       w_legal;
    logic [4:0] w_alu;

    assign w_is_lw  = (r_ir[6:0] == c_OP_LW);
    assign w_is_sw  = (r_ir[6:0] == c_OP_SW);
    assign w_is_lui = (r_ir[6:0] == c_OP_LUI);
    assign w_is_r   = (r_ir[6:0] == c_OP_R);

    // {funct7, funct3} selects the R-type operation; anything else is illegal.
    always_comb begin
        w_r_alu = 5'b00000;
        w_r_ok  = 1'b1;
        case ({r_ir[31:25], r_ir[14:12]})
            {7'h00, 3'b000}: w_r_alu = 5'b00000;
            {7'h20, 3'b000}: w_r_alu = 5'b00011;
            {7'h00, 3'b111}: w_r_alu = 5'b00001;
            {7'h00, 3'b110}: w_r_alu = 5'b00010;
            {7'h00, 3'b001}: w_r_alu = 5'b00100;
            {7'h00, 3'b101}: w_r_alu = 5'b00101;
            {7'h20, 3'b101}: w_r_alu = 5'b00110;
            default:         w_r_ok  = 1'b0;
        endcase
    end

    assign w_legal = w_is_lw | w_is_sw | w_is_lui | (w_is_r & w_r_ok);
    assign w_alu   = w_is_lui ? 5'b10011 : (w_is_r ? w_r_alu : 5'b00000);

    // ------------------------------------------------------------------
    // Issue gating
    // ------------------------------------------------------------------
    logic w_issue_ok;
    logic w_at_limit;
    logic w_fire;

    assign w_at_limit = (pc >= pc_limit);
    assign w_fire     = (r_state == c_IDLE) && !w_at_limit && run && w_issue_ok;

`ifdef MC_CTRL_STEP_EN
    logic r_step_pend;

    assign w_issue_ok = !step_mode || r_step_pend;

    // A pending step is consumed by the next issue; further pulses while
    // one is already pending are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_pend <= 1'b0;
        end else if (w_fire) begin
            r_step_pend <= 1'b0;
        end else if (step) begin
            r_step_pend <= 1'b1;
        end
    end
`else
    logic w_unused_step;

    assign w_issue_ok    = 1'b1;
    assign w_unused_step = step & step_mode;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_at_limit) begin
                    w_next = c_HALT;
                end else if (w_fire) begin
                    w_next = c_FETCH;
                end
            end
            c_FETCH:  w_next = c_DECODE;
            c_DECODE: w_next = w_legal ? c_EXEC : c_HALT;
            c_EXEC:   w_next = (w_is_lw || w_is_sw) ? c_MEM : c_WB;
            c_MEM:    w_next = w_is_sw ? c_IDLE : c_WB;
            c_WB:     w_next = c_IDLE;
            c_HALT:   w_next = c_HALT;
            default:  w_next = c_HALT;
        endcase
    end

    // An instruction retires in WB, or in MEM for a store (no writeback).
    logic w_retire;
    assign w_retire = (r_state == c_WB) || ((r_state == c_MEM) && w_is_sw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ir      <= 32'd0;
            r_retired <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_FETCH) begin
                r_ir <= ins;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            if ((r_state == c_DECODE) && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs; rst forces every control low in the cycle it is seen
    // so an instruction interrupted by reset never commits anything.
    // ------------------------------------------------------------------
    logic w_ctl_en;
    assign w_ctl_en = !rst && ((r_state == c_EXEC) || (r_state == c_MEM) ||
                               (r_state == c_WB));

    assign alu_op  = w_ctl_en ? w_alu : 5'b00000;
    assign b_sel   = w_ctl_en && (w_is_lw || w_is_sw || w_is_lui);
    assign imm_s   = w_ctl_en && w_is_sw;
    assign rf_we   = !rst && (r_state == c_WB);
    assign wd_sel  = !rst && (r_state == c_WB) && w_is_lw;
    assign mem_we  = !rst && (r_state == c_MEM) && w_is_sw;
    assign pc_we   = !rst && w_retire;
    assign halted  = !rst && (r_state == c_HALT);

    assign state   = r_state;
    assign ir      = r_ir;
    assign retired = r_retired;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. A schedule-based model
//               (per-instruction phase lists derived from the instruction
//               class) predicts every output each cycle; directed literal
//               checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, step, step_mode;
    logic [31:0] ins, pc, pc_limit;
    logic [31:0] ir, retired;
    logic        pc_we, rf_we, mem_we, wd_sel, b_sel, imm_s, halted, illegal;
    logic [4:0]  alu_op;
    logic [2:0]  state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .step_mode(step_mode),
        .ins(ins), .pc(pc), .pc_limit(pc_limit), .ir(ir),
        .pc_we(pc_we), .rf_we(rf_we), .mem_we(mem_we), .wd_sel(wd_sel),
        .b_sel(b_sel), .imm_s(imm_s), .alu_op(alu_op), .state(state),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: instruction classes and phase schedules
    // ------------------------------------------------------------------
    localparam int K_LW = 0, K_SW = 1, K_LUI = 2, K_ADD = 3, K_SUB = 4, K_AND = 5,
                   K_OR = 6, K_SLL = 7, K_SRL = 8, K_SRA = 9, K_BAD = 10;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_HALT = 6;

    int alu_tab [11] = '{0, 0, 19, 0, 3, 1, 2, 4, 5, 6, 0};

    function automatic int classify(input logic [31:0] w);
        logic [9:0] f;
        f = {w[31:25], w[14:12]};
        if (w[6:0] == 7'h03) return K_LW;
        if (w[6:0] == 7'h23) return K_SW;
        if (w[6:0] == 7'h37) return K_LUI;
        if (w[6:0] == 7'h33) begin
            if (f == {7'h00, 3'd0}) return K_ADD;
            if (f == {7'h20, 3'd0}) return K_SUB;
            if (f == {7'h00, 3'd7}) return K_AND;
            if (f == {7'h00, 3'd6}) return K_OR;
            if (f == {7'h00, 3'd1}) return K_SLL;
            if (f == {7'h00, 3'd5}) return K_SRL;
            if (f == {7'h20, 3'd5}) return K_SRA;
        end
        return K_BAD;
    endfunction

    typedef struct {
        int phase;
        int cls;
        bit last;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    logic [31:0] m_ir, m_ret;
    bit          m_ill, m_halt, m_pend, m_valid = 0, m_fire;
    int          ph, cl;
    logic [79:0] ev, av;
    int          mem_cnt = 0, rf_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_gated_outputs",
                {24'd0, pc_we, rf_we, mem_we, wd_sel, b_sel, imm_s, halted, alu_op, 1'b0},
                32'd0);
            q.delete();
            m_ir = 0; m_ret = 0; m_ill = 0; m_halt = 0; m_pend = 0; m_valid = 1;
        end else if (m_valid) begin
            if (mem_we) mem_cnt++;
            if (rf_we)  rf_cnt++;
            // expected outputs for this cycle
            if (q.size() != 0) begin
                ph = q[0].phase; cl = q[0].cls;
            end else begin
                ph = m_halt ? P_HALT : P_IDLE; cl = K_BAD;
            end
            ev = '0;
            ev[79:77] = 3'(ph);
            ev[76:45] = m_ir;
            ev[44:13] = m_ret;
            ev[12]    = m_ill;
            ev[11]    = (ph == P_HALT);
            if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
                ev[10] = q[0].last;
                ev[9]  = (ph == P_WB);
                ev[8]  = (ph == P_MEM) && (cl == K_SW);
                ev[7]  = (ph == P_WB) && (cl == K_LW);
                ev[6]  = (cl == K_LW) || (cl == K_SW) || (cl == K_LUI);
                ev[5]  = (cl == K_SW);
                ev[4:0] = 5'(alu_tab[cl]);
            end
            av = {state, ir, retired, illegal, halted, pc_we, rf_we, mem_we,
                  wd_sel, b_sel, imm_s, alu_op};
            n_tests++;
            if (av !== ev) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, av, ev);
            end
            // advance model across the coming edge
            m_fire = 0;
            if (m_halt) begin
            end else if (q.size() == 0) begin
                if (pc >= pc_limit) begin
                    m_halt = 1;
                end else begin
`ifdef MC_CTRL_STEP_EN
                    m_fire = run && (!step_mode || m_pend);
`else
                    m_fire = run;
`endif
                    if (m_fire) q.push_back('{P_FETCH, K_BAD, 1'b0});
                end
            end else begin
                e = q.pop_front();
                if (e.phase == P_FETCH) begin
                    m_ir = ins;
                    q.push_back('{P_DECODE, classify(ins), 1'b0});
                end else if (e.phase == P_DECODE) begin
                    if (e.cls == K_BAD) begin
                        m_halt = 1; m_ill = 1;
                    end else if (e.cls == K_LW) begin
                        q.push_back('{P_EXEC, e.cls, 1'b0});
                        q.push_back('{P_MEM, e.cls, 1'b0});
                        q.push_back('{P_WB, e.cls, 1'b1});
                    end else if (e.cls == K_SW) begin
                        q.push_back('{P_EXEC, e.cls, 1'b0});
                        q.push_back('{P_MEM, e.cls, 1'b1});
                    end else begin
                        q.push_back('{P_EXEC, e.cls, 1'b0});
                        q.push_back('{P_WB, e.cls, 1'b1});
                    end
                end else if (e.last) begin
                    m_ret = m_ret + 32'd1;
                end
            end
`ifdef MC_CTRL_STEP_EN
            if (m_fire) m_pend = 0;
            else if (step) m_pend = 1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    localparam logic [31:0] I_LUI = 32'h123450B7;
    localparam logic [31:0] I_SW  = 32'h00102223;
    localparam logic [31:0] I_LW  = 32'h00402103;
    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_MUL = 32'h022081B3;

    logic [31:0] r_tab_ins [5] = '{32'h0020F1B3, 32'h0020E1B3, 32'h002091B3,
                                   32'h0020D1B3, 32'h4020D1B3};
    logic [4:0]  r_tab_alu [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b00101, 5'b00110};
    logic [31:0] r0;

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0; step_mode = 1'b0;
        ins = I_LUI; pc = 32'h0; pc_limit = 32'h0010_0000;
        do_reset();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_ir", ir, 32'd0);
        chk("reset_retired", retired, 32'd0);

        // lui: WB in cycle 5
        cyc(4);
        chk("lui_rf_we", {31'd0, rf_we}, 32'd1);
        chk("lui_alu_op", {27'd0, alu_op}, 32'h13);
        chk("lui_b_sel", {31'd0, b_sel}, 32'd1);
        cyc();
        chk("lui_retired", retired, 32'd1);

        // sw
        ins = I_SW; r0 = retired; mem_cnt = 0; rf_cnt = 0;
        cyc(4);
        chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_imm_s", {31'd0, imm_s}, 32'd1);
        cyc();
        chk("sw_mem_we_count", mem_cnt, 32'd1);
        chk("sw_rf_we_count", rf_cnt, 32'd0);
        chk("sw_retired", retired, r0 + 32'd1);

        // lw: WB in cycle 6
        ins = I_LW;
        cyc(5);
        chk("lw_wd_sel", {31'd0, wd_sel}, 32'd1);
        chk("lw_rf_we", {31'd0, rf_we}, 32'd1);
        cyc();

        // add then sub
        ins = I_ADD;
        cyc(3);
        chk("add_alu_op", {27'd0, alu_op}, 32'h00);
        chk("add_b_sel", {31'd0, b_sel}, 32'd0);
        cyc(2);
        ins = I_SUB;
        cyc(3);
        chk("sub_alu_op", {27'd0, alu_op}, 32'h03);
        chk("sub_b_sel", {31'd0, b_sel}, 32'd0);
        cyc(2);

        // remaining R-type ops
        for (int k = 0; k < 5; k++) begin
            ins = r_tab_ins[k];
            cyc(3);
            chk("rtype_alu_op", {27'd0, alu_op}, {27'd0, r_tab_alu[k]});
            cyc(2);
        end

        // run drops mid-instruction: instruction completes, then holds IDLE
        ins = I_LUI; r0 = retired;
        cyc(2);
        run = 1'b0;
        cyc(6);
        chk("run_drop_state", {29'd0, state}, 32'd0);
        chk("run_drop_retired", retired, r0 + 32'd1);
        run = 1'b1;

        // reset during lw WB: enables suppressed, back to IDLE
        ins = I_LW;
        cyc(5);
        rst = 1'b1;
        #1;
        chk("rst_mid_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_mid_pc_we", {31'd0, pc_we}, 32'd0);
        cyc();
        rst = 1'b0;
        chk("rst_mid_state", {29'd0, state}, 32'd0);
        chk("rst_mid_retired", retired, 32'd0);

        // illegal R-type funct7
        ins = I_MUL;
        cyc(3);
        chk("mul_halted", {31'd0, halted}, 32'd1);
        chk("mul_illegal", {31'd0, illegal}, 32'd1);
        do_reset();
        chk("mul_cleared", {30'd0, illegal, halted}, 32'd0);

        // all-ones instruction; HALT absorbs even with run toggling
        ins = 32'hFFFF_FFFF;
        cyc(3);
        chk("ones_state", {29'd0, state}, 32'd6);
        run = 1'b0;
        cyc(3);
        run = 1'b1;
        cyc(2);
        chk("ones_still_halted", {30'd0, illegal, halted}, 32'd3);
        do_reset();

        // pc bound: last legal address issues, bound itself halts
        ins = I_LUI; pc = 32'h0040_0008; pc_limit = 32'h0040_000C;
        cyc(5);
        chk("limit_minus4_retired", retired, 32'd1);
        pc = 32'h0040_000C;
        cyc();
        chk("limit_state", {29'd0, state}, 32'd6);
        chk("limit_not_illegal", {31'd0, illegal}, 32'd0);
        pc = 32'h0;
        do_reset();

`ifdef MC_CTRL_STEP_EN
        // single-step: no issue without a step, two pulses -> two retires
        step_mode = 1'b1;
        cyc(4);
        chk("step_wait_state", {29'd0, state}, 32'd0);
        chk("step_wait_retired", retired, 32'd0);
        step = 1'b1; cyc(); step = 1'b0;
        cyc(2);
        step = 1'b1; cyc(); step = 1'b0;
        cyc(15);
        chk("step_two_retired", retired, 32'd2);
        chk("step_idle", {29'd0, state}, 32'd0);
        step_mode = 1'b0;
`else
        // step inputs are ignored: issue proceeds on run alone
        step_mode = 1'b1;
        cyc(5);
        chk("nostep_retired", retired, 32'd1);
        step_mode = 1'b0;
`endif
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Reset rst SHALL be synchronous, active-high; clock clk; all state SHALL update on posedge clk only.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 run  in  1  level; 1 permits instruction issue, 0 parks the FSM in IDLE at the next instruction boundary.
REQ-005 step  in  1  single-cycle pulse; issues one instruction in step mode (see REQ-030).
REQ-006 step_mode  in  1  level; 1 selects single-step issue.
REQ-007 ins  in  32  instruction word from instruction ROM at current PC.
REQ-008 pc  in  32  current PC value.
REQ-009 pc_limit  in  32  first address not to be executed.
REQ-010 ir  out  32  latched instruction register.
REQ-011 pc_we  out  1  PC advance enable (PC <= PC+4).
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 mem_we  out  1  data-RAM write enable.
REQ-014 wd_sel  out  1  writeback select, 1 = RAM data, 0 = ALU result.
REQ-015 b_sel  out  1  ALU operand B select, 1 = sign-extended immediate, 0 = rs2.
REQ-016 imm_s  out  1  immediate format, 1 = S-type {ir[31:25],ir[11:7]}, 0 = I-type ir[31:20].
REQ-017 alu_op  out  5  ALU opcode.
REQ-018 state  out  3  current FSM state encoding.
REQ-019 halted  out  1  FSM in HALT.
REQ-020 illegal  out  1  sticky; HALT was entered on an undecodable instruction.
REQ-021 retired  out  32  count of completed instructions.

Function
REQ-022 States/encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 SHALL map to HALT next cycle.
REQ-023 IDLE -> HALT if pc >= pc_limit (unsigned); else -> FETCH if run=1 and issue permitted (REQ-030); else stay.
REQ-024 FETCH: ir <= ins at cycle end; -> DECODE.
REQ-025 DECODE on ir[6:0]: 0000011 lw, 0100011 sw, 0110111 lui, 0110011 R-type -> EXEC; any other -> HALT, illegal <= 1.
REQ-026 R-type with (funct7,funct3) not in {add 00/000, sub 20/000, and 00/111, or 00/110, sll 00/001, srl 00/101, sra 20/101} SHALL be illegal.
REQ-027 EXEC -> MEM for lw/sw; -> WB for lui/R-type.
REQ-028 MEM: sw asserts mem_we this cycle only, then -> IDLE with pc_we and retire; lw -> WB.
REQ-029 WB: rf_we=1, wd_sel=1 for lw else 0; pc_we=1; retired += 1 (wraps at 2^32); -> IDLE.
REQ-030 Issue permitted when step_mode=0, or (MC_STEP_EN) when a step pulse is pending.
REQ-031 Latency per instruction incl. IDLE: lw 6, sw 5, lui/R-type 5 cycles with run=1 continuously.
REQ-032 alu_op: add/lw/sw 00000, sub 00011, and 00001, or 00010, sll 00100, srl 00101, sra 00110, lui 10011; driven from ir in EXEC, MEM, WB; 00000 elsewhere.
REQ-033 b_sel=1 for lw/sw/lui, 0 for R-type; imm_s=1 only for sw.
REQ-034 Outputs rf_we, mem_we, pc_we SHALL be Moore functions of state and ir, never asserted together except pc_we with rf_we (WB) or pc_we with mem_we (sw MEM).
REQ-035 run falling mid-instruction SHALL NOT abort; current instruction completes, FSM then holds in IDLE.
REQ-036 HALT is absorbing; only rst exits.

Reset
REQ-037 rst: state=IDLE, ir=0, retired=0, illegal=0, step pending=0; all enables 0, alu_op=0, wd_sel/b_sel/imm_s=0, halted=0.
REQ-038 rst asserted mid-instruction SHALL suppress any enable in that cycle and return to IDLE next cycle.

Configuration
REQ-039 Macro MC_CTRL_STEP_EN: defined -> step pulse sets a pending flag, consumed on IDLE->FETCH, step pulses while pending are dropped; undefined -> step and step_mode ignored, issue governed by run only.

Verification
REQ-040 rst, run=1, ir sequence lui x1,0x12345 (0x123450B7) -> rf_we=1 in cycle 5 with alu_op=10011, b_sel=1, retired=1.
REQ-041 sw x1,4(x0) (0x00102223) -> mem_we high exactly one cycle, imm_s=1, rf_we never high, retired increments by 1.
REQ-042 lw x2,4(x0) (0x00402103) -> wd_sel=1 and rf_we=1 in cycle 6; add 0x002081B3 then sub 0x402081B3 -> alu_op 00000 then 00011, b_sel=0.
REQ-043 ins=0xFFFFFFFF -> HALT after DECODE, illegal=1, halted=1, no enables; only rst clears.
REQ-044 pc=pc_limit=0x0040000C at IDLE -> HALT; with MC_CTRL_STEP_EN, step_mode=1, two step pulses 3 cycles apart during one instruction -> exactly two instructions retire.
